// File: rtl/writeback_unit_pkg.sv
// Shared definitions for the write-back path.
// Register file and decode use the same defaults and entry record.
//   ADDRSIZE_DEF / WORDSIZE_DEF / DEPTH_DEF : default widths and load buffer depth
//   wb_entry_t                              : one pending register write {rd, data}
//   cnt_width()                             : width of an occupancy counter for a given depth
package writeback_unit_pkg;

    localparam int ADDRSIZE_DEF = 5;
    localparam int WORDSIZE_DEF = 64;
    localparam int DEPTH_DEF    = 2;

    typedef struct packed {
        logic [ADDRSIZE_DEF-1:0] rd;
        logic [WORDSIZE_DEF-1:0] data;
    } wb_entry_t;

    // A count must reach DEPTH itself, so it needs one bit more than a pointer.
    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/writeback_unit_if.sv
// Bus between the execute/load/decode stages and the write-back unit.
//   master : drives ALU results, load responses and decode source addresses
//   slave  : the write-back unit; returns ld_ready, the register file write
//            port (regwr/rd/rddata), pending flags and load buffer occupancy
interface writeback_unit_if
    import writeback_unit_pkg::*;
#(
    parameter int ADDRSIZE = ADDRSIZE_DEF,
    parameter int WORDSIZE = WORDSIZE_DEF,
    parameter int DEPTH    = DEPTH_DEF
);

    localparam int CNTW = cnt_width(DEPTH);

    logic                alu_valid;
    logic [ADDRSIZE-1:0] alu_rd;
    logic [WORDSIZE-1:0] alu_data;

    logic                ld_valid;
    logic                ld_ready;
    logic [ADDRSIZE-1:0] ld_rd;
    logic [WORDSIZE-1:0] ld_data;

    logic                regwr;
    logic [ADDRSIZE-1:0] rd;
    logic [WORDSIZE-1:0] rddata;

    logic [ADDRSIZE-1:0] rs1;
    logic [ADDRSIZE-1:0] rs2;
    logic                rs1_pend;
    logic                rs2_pend;

    logic [CNTW-1:0]     ld_count;

    modport master (
        output alu_valid, alu_rd, alu_data,
        output ld_valid, ld_rd, ld_data,
        output rs1, rs2,
        input  ld_ready, regwr, rd, rddata, rs1_pend, rs2_pend, ld_count
    );

    modport slave (
        input  alu_valid, alu_rd, alu_data,
        input  ld_valid, ld_rd, ld_data,
        input  rs1, rs2,
        output ld_ready, regwr, rd, rddata, rs1_pend, rs2_pend, ld_count
    );

endinterface

// File: rtl/writeback_unit_wb_fifo.sv
// Show-ahead load buffer for the write-back unit.
// Ports:
//   clk, rst_n            : clock, synchronous active-low reset (empties the buffer)
//   push, push_rd/data    : enqueue one entry
//   pop                   : dequeue the head; head_rd/head_data always show the head
//   count                 : number of valid entries (0..DEPTH)
//   entry_rd, entry_valid : every slot's rd and valid bit, for the pending compare
// The owner never pushes when full or pops when empty.
module wb_fifo
    import writeback_unit_pkg::*;
#(
    parameter int ADDRSIZE = ADDRSIZE_DEF,
    parameter int WORDSIZE = WORDSIZE_DEF,
    parameter int DEPTH    = DEPTH_DEF,
    parameter int CNTW     = cnt_width(DEPTH)
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            push,
    input  logic [ADDRSIZE-1:0]             push_rd,
    input  logic [WORDSIZE-1:0]             push_data,
    input  logic                            pop,
    output logic [ADDRSIZE-1:0]             head_rd,
    output logic [WORDSIZE-1:0]             head_data,
    output logic [CNTW-1:0]                 count,
    output logic [DEPTH-1:0][ADDRSIZE-1:0]  entry_rd,
    output logic [DEPTH-1:0]                entry_valid
);

    localparam int PTRW = $clog2(DEPTH);

    logic [DEPTH-1:0][ADDRSIZE-1:0] rd_mem;
    logic [WORDSIZE-1:0]            data_mem [DEPTH];
    logic [DEPTH-1:0]               valid_mem;
    logic [PTRW-1:0]                wr_ptr;
    logic [PTRW-1:0]                rd_ptr;
    logic [CNTW-1:0]                count_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count_q   <= '0;
            valid_mem <= '0;
        end else begin
            // Pop is applied before push so a push into the slot just freed wins.
            if (pop) begin
                valid_mem[rd_ptr] <= 1'b0;
                rd_ptr            <= rd_ptr + PTRW'(1);
            end
            if (push) begin
                valid_mem[wr_ptr] <= 1'b1;
                rd_mem[wr_ptr]    <= push_rd;
                wr_ptr            <= wr_ptr + PTRW'(1);
            end
            count_q <= count_q + CNTW'(push) - CNTW'(pop);
        end
    end

    // Payload needs no reset; it is qualified by valid_mem.
    always_ff @(posedge clk) begin
        if (rst_n && push) begin
            data_mem[wr_ptr] <= push_data;
        end
    end

    assign head_rd     = rd_mem[rd_ptr];
    assign head_data   = data_mem[rd_ptr];
    assign count       = count_q;
    assign entry_rd    = rd_mem;
    assign entry_valid = valid_mem;

endmodule

// File: rtl/writeback_unit.sv
// Write-back unit: merges ALU results and load responses onto the single
// register file write port, buffering loads that lose arbitration.
// Ports:
//   clk   : clock
//   rst_n : synchronous active-low reset
//   bus   : writeback_unit_if.slave
//           alu_*            ALU result, always accepted
//           ld_* / ld_ready  load response handshake
//           regwr/rd/rddata  registered register file write
//           rs1/rs2 -> rs1_pend/rs2_pend  in-flight write check for decode
//           ld_count         buffered load entries
module writeback_unit
    import writeback_unit_pkg::*;
#(
    parameter int ADDRSIZE = ADDRSIZE_DEF,
    parameter int WORDSIZE = WORDSIZE_DEF,
    parameter int DEPTH    = DEPTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    writeback_unit_if.slave  bus
);

    localparam int CNTW = cnt_width(DEPTH);

    logic                           ld_ready;
    logic                           ld_acc;
    logic [CNTW-1:0]                count;
    logic [ADDRSIZE-1:0]            head_rd;
    logic [WORDSIZE-1:0]            head_data;
    logic [DEPTH-1:0][ADDRSIZE-1:0] entry_rd;
    logic [DEPTH-1:0]               entry_valid;

    logic                push;
    logic                pop;
    logic                sel_valid;
    logic [ADDRSIZE-1:0] sel_rd;
    logic [WORDSIZE-1:0] sel_data;
    logic                sel_write;

    logic                regwr_q;
    logic [ADDRSIZE-1:0] rd_q;
    logic [WORDSIZE-1:0] rddata_q;

    logic                rs1_hit;
    logic                rs2_hit;

    // Ready looks only at the registered count; a same-cycle pop does not
    // open a slot until the next cycle.
    assign ld_ready = rst_n && (count != CNTW'(DEPTH));
    assign ld_acc   = bus.ld_valid && ld_ready;

    // Priority: ALU, then buffered head, then the incoming load directly.
    always_comb begin
        push      = 1'b0;
        pop       = 1'b0;
        sel_valid = 1'b0;
        sel_rd    = '0;
        sel_data  = '0;
        if (bus.alu_valid) begin
            sel_valid = 1'b1;
            sel_rd    = bus.alu_rd;
            sel_data  = bus.alu_data;
            push      = ld_acc;
        end else if (count != '0) begin
            sel_valid = 1'b1;
            sel_rd    = head_rd;
            sel_data  = head_data;
            pop       = 1'b1;
            push      = ld_acc;
        end else if (ld_acc) begin
            sel_valid = 1'b1;
            sel_rd    = bus.ld_rd;
            sel_data  = bus.ld_data;
        end
    end

    // x0 entries are consumed above but never reach the register file.
    assign sel_write = sel_valid && (sel_rd != '0);

    wb_fifo #(
        .ADDRSIZE (ADDRSIZE),
        .WORDSIZE (WORDSIZE),
        .DEPTH    (DEPTH),
        .CNTW     (CNTW)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push        (push),
        .push_rd     (bus.ld_rd),
        .push_data   (bus.ld_data),
        .pop         (pop),
        .head_rd     (head_rd),
        .head_data   (head_data),
        .count       (count),
        .entry_rd    (entry_rd),
        .entry_valid (entry_valid)
    );

    // rd/rddata hold their last written value when nothing is written.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            regwr_q  <= 1'b0;
            rd_q     <= '0;
            rddata_q <= '0;
        end else begin
            regwr_q <= sel_write;
            if (sel_write) begin
                rd_q     <= sel_rd;
                rddata_q <= sel_data;
            end
        end
    end

    // A write is in flight if it sits in the buffer or is on the port now.
    always_comb begin
        rs1_hit = regwr_q && (rd_q == bus.rs1);
        rs2_hit = regwr_q && (rd_q == bus.rs2);
        for (int i = 0; i < DEPTH; i++) begin
            if (entry_valid[i] && (entry_rd[i] == bus.rs1)) rs1_hit = 1'b1;
            if (entry_valid[i] && (entry_rd[i] == bus.rs2)) rs2_hit = 1'b1;
        end
    end

    assign bus.rs1_pend = (bus.rs1 != '0) && rs1_hit;
    assign bus.rs2_pend = (bus.rs2 != '0) && rs2_hit;
    assign bus.ld_ready = ld_ready;
    assign bus.regwr    = regwr_q;
    assign bus.rd       = rd_q;
    assign bus.rddata   = rddata_q;
    assign bus.ld_count = count;

endmodule

// File: tb/tb_writeback_unit.sv
module tb_writeback_unit;
    import writeback_unit_pkg::*;

    localparam int AW    = 5;
    localparam int DW    = 64;
    localparam int DEPTH = 2;
    localparam int NRAND = 3000;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    writeback_unit_if #(.ADDRSIZE(AW), .WORDSIZE(DW), .DEPTH(DEPTH)) bus ();

    writeback_unit #(.ADDRSIZE(AW), .WORDSIZE(DW), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic          rst;
        logic          av;
        logic [AW-1:0] ard;
        logic [DW-1:0] adata;
        logic          lv;
        logic [AW-1:0] lrd;
        logic [DW-1:0] ldata;
        logic [AW-1:0] r1;
        logic [AW-1:0] r2;
        logic          e_ready;
        logic          e_regwr;
        logic [AW-1:0] e_rd;
        logic [DW-1:0] e_data;
        logic [1:0]    e_cnt;
        logic          e_p1;
        logic          e_p2;
    } vec_t;

    function automatic vec_t mk(
        input logic rst, input logic av, input logic [AW-1:0] ard, input logic [DW-1:0] ad,
        input logic lv, input logic [AW-1:0] lrd, input logic [DW-1:0] ld,
        input logic [AW-1:0] r1, input logic [AW-1:0] r2,
        input logic er, input logic ew, input logic [AW-1:0] erd, input logic [DW-1:0] ed,
        input logic [1:0] ec, input logic ep1, input logic ep2);
        vec_t v;
        v.rst = rst; v.av = av; v.ard = ard; v.adata = ad;
        v.lv = lv; v.lrd = lrd; v.ldata = ld; v.r1 = r1; v.r2 = r2;
        v.e_ready = er; v.e_regwr = ew; v.e_rd = erd; v.e_data = ed;
        v.e_cnt = ec; v.e_p1 = ep1; v.e_p2 = ep2;
        return v;
    endfunction

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input vec_t v);
        rst_n         = v.rst;
        bus.alu_valid = v.av;
        bus.alu_rd    = v.ard;
        bus.alu_data  = v.adata;
        bus.ld_valid  = v.lv;
        bus.ld_rd     = v.lrd;
        bus.ld_data   = v.ldata;
        bus.rs1       = v.r1;
        bus.rs2       = v.r2;
    endtask

    // Reference model: buffered loads as an ordered queue plus the last write.
    wb_entry_t     mq[$];
    logic          m_regwr;
    logic [AW-1:0] m_rd;
    logic [DW-1:0] m_data;

    function automatic logic m_pend(input logic [AW-1:0] rs);
        if (rs == 0) return 1'b0;
        if (m_regwr && m_rd == rs) return 1'b1;
        foreach (mq[i]) if (mq[i].rd == rs) return 1'b1;
        return 1'b0;
    endfunction

    vec_t vecs[24];

    initial begin
        vec_t v;
        vecs = '{
            mk(0, 0, 0, 0,        1, 7, 'h77,   0, 0,   0, 0, 0, 0,        0, 0, 0),
            mk(0, 0, 0, 0,        1, 7, 'h77,   0, 0,   0, 0, 0, 0,        0, 0, 0),
            mk(1, 0, 0, 0,        0, 0, 0,      0, 0,   1, 0, 0, 0,        0, 0, 0),
            mk(1, 1, 5, 'hDEAD,   0, 0, 0,      5, 6,   1, 1, 5, 'hDEAD,   0, 1, 0),
            mk(1, 0, 0, 0,        0, 0, 0,      5, 6,   1, 0, 5, 'hDEAD,   0, 0, 0),
            mk(1, 1, 3, 'h11,     1, 4, 'h22,   4, 3,   1, 1, 3, 'h11,     1, 1, 1),
            mk(1, 0, 0, 0,        0, 0, 0,      4, 3,   1, 1, 4, 'h22,     0, 1, 0),
            mk(1, 0, 0, 0,        0, 0, 0,      4, 3,   1, 0, 4, 'h22,     0, 0, 0),
            mk(1, 1, 1, 'hA1,     1, 10, 'hB0,  10, 11, 1, 1, 1, 'hA1,     1, 1, 0),
            mk(1, 1, 2, 'hA2,     1, 11, 'hB1,  10, 11, 0, 1, 2, 'hA2,     2, 1, 1),
            mk(1, 1, 1, 'hA3,     1, 12, 'hB2,  12, 10, 0, 1, 1, 'hA3,     2, 0, 1),
            mk(1, 0, 0, 0,        1, 12, 'hB2,  12, 10, 1, 1, 10, 'hB0,    1, 0, 1),
            mk(1, 0, 0, 0,        1, 12, 'hB2,  12, 10, 1, 1, 11, 'hB1,    1, 1, 0),
            mk(1, 0, 0, 0,        0, 0, 0,      12, 10, 1, 1, 12, 'hB2,    0, 1, 0),
            mk(1, 0, 0, 0,        0, 0, 0,      12, 10, 1, 0, 12, 'hB2,    0, 0, 0),
            mk(1, 1, 0, 'hFF,     0, 0, 0,      0, 0,   1, 0, 12, 'hB2,    0, 0, 0),
            mk(1, 1, 9, 'h99,     1, 0, 'h55,   0, 9,   1, 1, 9, 'h99,     1, 0, 1),
            mk(1, 0, 0, 0,        0, 0, 0,      0, 9,   1, 0, 9, 'h99,     0, 0, 0),
            mk(1, 0, 0, 0,        1, 6, 'h66,   6, 0,   1, 1, 6, 'h66,     0, 1, 0),
            mk(1, 1, 1, 'hC1,     1, 13, 'hD0,  13, 14, 1, 1, 1, 'hC1,     1, 1, 0),
            mk(1, 1, 2, 'hC2,     1, 14, 'hD1,  13, 14, 0, 1, 2, 'hC2,     2, 1, 1),
            mk(0, 0, 0, 0,        0, 0, 0,      13, 14, 0, 0, 0, 0,        0, 0, 0),
            mk(1, 0, 0, 0,        0, 0, 0,      13, 14, 1, 0, 0, 0,        0, 0, 0),
            mk(1, 0, 0, 0,        0, 0, 0,      13, 14, 1, 0, 0, 0,        0, 0, 0)
        };

        // Each row is held for one edge; expectations are the state just after it.
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            drive(vecs[i]);
            @(posedge clk);
            #1;
            check($sformatf("vec%0d ld_ready", i), DW'(bus.ld_ready), DW'(vecs[i].e_ready));
            check($sformatf("vec%0d regwr", i),    DW'(bus.regwr),    DW'(vecs[i].e_regwr));
            check($sformatf("vec%0d rd", i),       DW'(bus.rd),       DW'(vecs[i].e_rd));
            check($sformatf("vec%0d rddata", i),   bus.rddata,        vecs[i].e_data);
            check($sformatf("vec%0d ld_count", i), DW'(bus.ld_count), DW'(vecs[i].e_cnt));
            check($sformatf("vec%0d rs1_pend", i), DW'(bus.rs1_pend), DW'(vecs[i].e_p1));
            check($sformatf("vec%0d rs2_pend", i), DW'(bus.rs2_pend), DW'(vecs[i].e_p2));
        end

        // Random traffic against the queue model, starting from the reset state above.
        mq.delete();
        m_regwr = 1'b0;
        m_rd    = '0;
        m_data  = '0;
        for (int c = 0; c < NRAND; c++) begin
            logic      exp_ready;
            logic      acc;
            logic      sel;
            wb_entry_t s;
            @(negedge clk);
            v.rst   = ($urandom_range(0, 79) != 0);
            v.av    = ($urandom_range(0, 2) == 0);
            v.ard   = AW'($urandom_range(0, 7));
            v.adata = {$urandom, $urandom};
            v.lv    = ($urandom_range(0, 1) == 0);
            v.lrd   = AW'($urandom_range(0, 7));
            v.ldata = {$urandom, $urandom};
            v.r1    = AW'($urandom_range(0, 7));
            v.r2    = AW'($urandom_range(0, 7));
            drive(v);
            #1;
            exp_ready = v.rst && (mq.size() < DEPTH);
            check("rand ld_ready", DW'(bus.ld_ready), DW'(exp_ready));
            acc = v.lv && exp_ready;

            @(posedge clk);
            if (!v.rst) begin
                mq.delete();
                m_regwr = 1'b0;
                m_rd    = '0;
                m_data  = '0;
            end else begin
                sel = 1'b1;
                if (v.av) begin
                    s.rd = v.ard; s.data = v.adata;
                    if (acc) mq.push_back('{v.lrd, v.ldata});
                end else if (mq.size() != 0) begin
                    s = mq.pop_front();
                    if (acc) mq.push_back('{v.lrd, v.ldata});
                end else if (acc) begin
                    s.rd = v.lrd; s.data = v.ldata;
                end else begin
                    sel = 1'b0;
                    s = '0;
                end
                m_regwr = sel && (s.rd != 0);
                if (m_regwr) begin
                    m_rd   = s.rd;
                    m_data = s.data;
                end
            end
            #1;
            check("rand regwr",    DW'(bus.regwr),    DW'(m_regwr));
            check("rand rd",       DW'(bus.rd),       DW'(m_rd));
            check("rand rddata",   bus.rddata,        m_data);
            check("rand ld_count", DW'(bus.ld_count), DW'(mq.size()));
            check("rand rs1_pend", DW'(bus.rs1_pend), DW'(m_pend(v.r1)));
            check("rand rs2_pend", DW'(bus.rs2_pend), DW'(m_pend(v.r2)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/writeback_unit.md
# writeback_unit

Write-side companion of the integer register file: merges single-cycle ALU results and variable-latency load responses into the register file's single write port (regwr/rd/rddata). ALU results always win the port and loads that lose arbitration are buffered in a small FIFO. Writes to x0 are suppressed. The block also reports, per source-register address, whether a write to it is still in flight so the decode stage can stall.

## Interface
Parameters:
- ADDRSIZE, 5, bits per register address
- WORDSIZE, 64, register data width
- DEPTH, 2, load buffer entries (power of 2, ≥2)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  reset; synchronous, active-low
- alu_valid  in  1  ALU result present this cycle (no ready; always accepted)
- alu_rd  in  ADDRSIZE  ALU destination register
- alu_data  in  WORDSIZE  ALU result
- ld_valid  in  1  load response present
- ld_ready  out  1  load response accepted when ld_valid && ld_ready
- ld_rd  in  ADDRSIZE  load destination register
- ld_data  in  WORDSIZE  load data
- regwr  out  1  register file write enable
- rd  out  ADDRSIZE  register file write address
- rddata  out  WORDSIZE  register file write data
- rs1, rs2  in  ADDRSIZE  decode-stage source addresses
- rs1_pend, rs2_pend  out  1  a write to rs1/rs2 is still outstanding
- ld_count  out  $clog2(DEPTH)+1  buffered load entries

## Operation
- Output register (regwr, rd, rddata) captures at most one write per cycle. Selection priority: ALU > FIFO head > incoming accepted load (bypass).
- alu_valid: the ALU result is selected. An accepted load in the same cycle is pushed to the FIFO.
- No ALU and FIFO non-empty: the head is popped and selected. An accepted load is pushed in the same cycle (simultaneous push/pop is legal when full-minus-zero, i.e. count unchanged).
- No ALU and FIFO empty: an accepted load bypasses the FIFO and is selected directly.
- ld_ready = rst_n && (ld_count != DEPTH). It depends only on registered count, not on same-cycle drain. A full FIFO under continuous ALU traffic keeps ld_ready low; starvation is permitted.
- x0 rule: when the selected entry has rd == 0, it is consumed but regwr is registered 0.
- When nothing is selected, or the selected rd is 0, regwr <= 0 and rd/rddata hold their previous values.
- Pending: rsN_pend = (rsN != 0) && (rsN matches a valid FIFO entry's rd, or regwr && rd == rsN). Purely combinational from current state.
- Reset (rst_n low at edge): regwr=0, rd=0, rddata=0, FIFO emptied, ld_count=0. While rst_n is low, ld_ready=0 and inputs are ignored. Reset mid-stream discards buffered loads.

## Timing
- Latency: input accepted at edge t → regwr high during cycle t+1 → register file updated at end of t+1.
- ALU + load same cycle, FIFO empty, idle after: ALU write in t+1, load write in t+2.
- Throughput: one write per cycle. FIFO occupancy changes by −1, 0 or +1 per cycle.
- ld_ready returns high the cycle after a pop from a full FIFO.

## Structure
- Shared package: ADDRSIZE/WORDSIZE defaults and a wb_entry record {rd, data}. Also used by register file and decode.
- Sub-module wb_fifo: synchronous show-ahead FIFO (DEPTH entries, wrap-around pointers plus count, push/pop same cycle). It exposes all entries' rd and valid bits for the pending compare.
- Top level: priority select, x0 suppression, output register, pending compare.

## Test plan
- Reset: hold rst_n=0 two cycles with ld_valid=1 → ld_ready=0, regwr=0, rd=0, rddata=0. First cycle after release → ld_ready=1.
- ALU only: alu_rd=5, alu_data=0xDEAD → next cycle regwr=1, rd=5, rddata=0xDEAD. Following idle cycle → regwr=0, rd still 5.
- Collision: same cycle alu(rd=3, 0x11) and load(rd=4, 0x22), then idle → t+1 writes x3=0x11, t+2 writes x4=0x22. During t+1, ld_count=1 and rs1=4 gives rs1_pend=1.
- Backpressure: alu_valid held high and 3 loads offered → 2 accepted, ld_ready=0. Drop alu_valid → loads drain in order on consecutive cycles, and ld_ready=1 one cycle after the first pop.
- x0: ALU write rd=0 data=0xFF → regwr stays 0. rs1=0 → rs1_pend=0 even with an rd=0 load buffered.
- Reset mid-operation: 2 loads buffered, rst_n=0 for one edge → ld_count=0, no further writes, rs*_pend=0.
